// File: rtl/web_pkg.sv
// Shared definitions for the web refill station: resource kinds, FSM states
// and reservoir defaults.
package web_pkg;

  localparam int unsigned RES_W_DEF       = 10;
  localparam int unsigned AMOUNT_W        = 9;
  localparam int unsigned FLUID_INIT_DEF  = 255;
  localparam int unsigned ENERGY_INIT_DEF = 1023;
  localparam int unsigned TRACER_INIT_DEF = 255;
  localparam int unsigned LOW_THRESH_DEF  = 16;

  typedef enum logic [1:0] {
    RES_FLUID   = 2'b00,
    RES_ENERGY  = 2'b01,
    RES_TRACER  = 2'b10,
    RES_INVALID = 2'b11
  } res_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DISPENSE = 2'b01,
    ST_DONE     = 2'b10
  } state_e;

endpackage

// File: rtl/reservoir_counter.sv
// One reservoir level: reloads to INIT on reset or load, and decrements
// with a floor at zero.
module reservoir_counter #(
  parameter int unsigned W    = 10,
  parameter int unsigned INIT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         dec_i,
  output logic [W-1:0] level_o,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] level_q, level_d;

  // Load wins over decrement; decrement never goes below zero.
  always_comb begin
    level_d = level_q;
    if (load_i) begin
      level_d = W'(INIT);
    end else if (dec_i && (level_q != '0)) begin
      level_d = level_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= W'(INIT);
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign zero_o  = (level_q == '0);
  assign one_o   = (level_q == W'(1));

endmodule

// File: rtl/web_refill_station.sv
// Refill station: accepts (kind, amount) requests and streams units out of
// three reservoirs. Optional low-level warning output under REFILL_STATUS_EN.
module web_refill_station
  import web_pkg::*;
#(
  parameter int unsigned RES_W       = RES_W_DEF,
  parameter int unsigned FLUID_INIT  = FLUID_INIT_DEF,
  parameter int unsigned ENERGY_INIT = ENERGY_INIT_DEF,
  parameter int unsigned TRACER_INIT = TRACER_INIT_DEF
`ifdef REFILL_STATUS_EN
  ,
  parameter int unsigned LOW_THRESH  = LOW_THRESH_DEF
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_kind,
  input  logic [AMOUNT_W-1:0] req_amount,
  output logic                unit_valid,
  input  logic                unit_ready,
  output logic [1:0]          unit_kind,
  output logic                done,
  output logic                short,
  output logic [RES_W-1:0]    delivered,
  input  logic                restock,
  output logic [RES_W-1:0]    level_f,
  output logic [RES_W-1:0]    level_e,
  output logic [RES_W-1:0]    level_t
`ifdef REFILL_STATUS_EN
  ,
  output logic                low_warn
`endif
);

  state_e           state_q, state_d;
  res_kind_e        kind_q, kind_d;
  logic [RES_W-1:0] remaining_q, remaining_d;
  logic [RES_W-1:0] delivered_q, delivered_d;
  logic             short_q, short_d;

  logic [2:0] dec;
  logic [2:0] zero;
  logic [2:0] one;
  logic       restock_load;
  logic       req_level_zero;
  logic       cur_level_one;

  reservoir_counter #(.W(RES_W), .INIT(FLUID_INIT)) u_fluid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (restock_load),
    .dec_i   (dec[0]),
    .level_o (level_f),
    .zero_o  (zero[0]),
    .one_o   (one[0])
  );

  reservoir_counter #(.W(RES_W), .INIT(ENERGY_INIT)) u_energy (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (restock_load),
    .dec_i   (dec[1]),
    .level_o (level_e),
    .zero_o  (zero[1]),
    .one_o   (one[1])
  );

  reservoir_counter #(.W(RES_W), .INIT(TRACER_INIT)) u_tracer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (restock_load),
    .dec_i   (dec[2]),
    .level_o (level_t),
    .zero_o  (zero[2]),
    .one_o   (one[2])
  );

  // Level of the reservoir named by the incoming request, and of the latched one.
  always_comb begin
    req_level_zero = 1'b0;
    cur_level_one  = 1'b0;
    case (req_kind)
      RES_FLUID:  req_level_zero = zero[0];
      RES_ENERGY: req_level_zero = zero[1];
      RES_TRACER: req_level_zero = zero[2];
      default:    req_level_zero = 1'b0;
    endcase
    case (kind_q)
      RES_FLUID:  cur_level_one = one[0];
      RES_ENERGY: cur_level_one = one[1];
      RES_TRACER: cur_level_one = one[2];
      default:    cur_level_one = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    remaining_d  = remaining_q;
    delivered_d  = delivered_q;
    short_d      = short_q;
    req_ready    = 1'b0;
    unit_valid   = 1'b0;
    done         = 1'b0;
    dec          = 3'b000;
    restock_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready    = !restock;
        restock_load = restock;
        if (req_valid && !restock) begin
          kind_d      = res_kind_e'(req_kind);
          remaining_d = RES_W'(req_amount);
          delivered_d = '0;
          if ((req_amount == '0) || (req_kind == RES_INVALID) || req_level_zero) begin
            state_d = ST_DONE;
            short_d = (req_amount != '0) || (req_kind == RES_INVALID);
          end else begin
            state_d = ST_DISPENSE;
            short_d = 1'b0;
          end
        end
      end
      ST_DISPENSE: begin
        unit_valid = 1'b1;
        if (unit_ready) begin
          case (kind_q)
            RES_FLUID:  dec[0] = 1'b1;
            RES_ENERGY: dec[1] = 1'b1;
            RES_TRACER: dec[2] = 1'b1;
            default:    dec    = 3'b000;
          endcase
          remaining_d = remaining_q - RES_W'(1);
          delivered_d = (delivered_q == '1) ? delivered_q : delivered_q + RES_W'(1);
          // Meeting the amount takes priority over running dry on the same unit.
          if (remaining_q == RES_W'(1)) begin
            state_d = ST_DONE;
            short_d = 1'b0;
          end else if (cur_level_one) begin
            state_d = ST_DONE;
            short_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      kind_q      <= RES_FLUID;
      remaining_q <= '0;
      delivered_q <= '0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      remaining_q <= remaining_d;
      delivered_q <= delivered_d;
      short_q     <= short_d;
    end
  end

  assign unit_kind = kind_q;
  assign delivered = delivered_q;
  assign short     = done && short_q;

`ifdef REFILL_STATUS_EN
  logic low_warn_q;

  // A restock clears the warning immediately rather than waiting for the reload.
  always_ff @(posedge clk) begin
    if (!rst_n || restock_load) begin
      low_warn_q <= 1'b0;
    end else begin
      low_warn_q <= (level_f < RES_W'(LOW_THRESH)) ||
                    (level_e < RES_W'(LOW_THRESH)) ||
                    (level_t < RES_W'(LOW_THRESH));
    end
  end

  assign low_warn = low_warn_q;
`endif

endmodule
